alarm_sequencer: RTL and testbench
==================================

# alarm_sequencer

Alarm ringing controller for the digital-clock design. Watches the running time and the stored alarm time and sequences the alarm through ring, snooze and auto-stop. It drives the buzzer output and the alarm status flags, replacing the plain "time equals alarm" compare gate. All time inputs are 7-bit binary values taken straight from the hour, minute and second counters.

## Interface
- `RING_SEC`, default 60: ring duration in seconds before auto-timeout; legal range 1..1023.
- `SNOOZE_SEC`, default 300: snooze duration in seconds; legal range 1..1023.
- `MAX_SNOOZE`, default 3: maximum snoozes per alarm event; legal range 0..7.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: one-`clk`-cycle pulse once per second, aligned with the seconds counter update.
- `cur_h`, `cur_m`, `cur_s` in 7 each: current time (0..23, 0..59, 0..59).
- `alm_h`, `alm_m` in 7 each: alarm time.
- `alarm_en` in 1: alarm armed (level).
- `btn_snooze`, `btn_stop` in 1: synchronized button levels; edge-detected internally.
- `som` out 1: buzzer drive.
- `ringing` out 1: state is RING.
- `snoozing` out 1: state is SNOOZE.
- `snooze_left` out 3: `MAX_SNOOZE` minus snoozes used.
- `missed` out 1: sticky flag set when the alarm ended without user action.

## Operation
- **States:** IDLE, RING, SNOOZE.
- **Internal registers:** `sec_cnt` (10 bits), `snz_cnt` (3 bits), `phase`, `match_q`, `snz_q`, `stop_q`.
- **Trigger:**
  - `match = (cur_h==alm_h) & (cur_m==alm_m) & (cur_s==0)`.
  - `trig = match & ~match_q & alarm_en`.
  - `match_q` registers `match` every cycle.
  - Result: one trigger per alarm minute, with no retrigger while the time stays at the match value.
- **Button edges:** `snz_rise = btn_snooze & ~snz_q` and `stop_rise = btn_stop & ~stop_q`.
- **Priority in RING and SNOOZE, highest first:**
  1. `alarm_en==0`: go to IDLE.
  2. `stop_rise`: go to IDLE.
  3. `snz_rise`.
  4. Timeout.
- **IDLE:**
  - On `trig`: go to RING with `sec_cnt=0`, `snz_cnt=0`, `phase=1`.
  - All buttons are ignored.
- **RING:**
  - On `tick`: toggle `phase` and increment `sec_cnt`.
  - On `snz_rise` with `snz_cnt<MAX_SNOOZE`: go to SNOOZE, `snz_cnt+1`, `sec_cnt=0`.
  - On `snz_rise` with `snz_cnt==MAX_SNOOZE`: ignored.
  - **Timeout** (`tick` while `sec_cnt==RING_SEC-1`):
    - If `snz_cnt<MAX_SNOOZE`: auto-snooze, same action as a snooze press.
    - Otherwise: go to IDLE and set `missed=1`.
- **SNOOZE:**
  - On `tick`: increment `sec_cnt`.
  - On `tick` while `sec_cnt==SNOOZE_SEC-1`: go to RING with `sec_cnt=0`, `phase=1`.
  - `snz_rise` is ignored.
- **`trig` outside IDLE:** ignored.
- **`missed`:** cleared by `stop_rise` in any state, or by `alarm_en==0`. Clearing takes priority over setting in the same cycle only if both occur, which cannot happen because `alarm_en==0` forbids the timeout.
- **Outputs:**
  - `som = ringing & phase`, giving 1 s on / 1 s off starting with "on".
  - `snooze_left = MAX_SNOOZE - snz_cnt`.
- **Counter width:** `sec_cnt` never exceeds `max(RING_SEC, SNOOZE_SEC)-1`. There is no wrap case.

## Timing
- **Reset values:** state IDLE, `som=0`, `ringing=0`, `snoozing=0`, `snooze_left=MAX_SNOOZE`, `missed=0`, `sec_cnt=0`, `phase=0`.
  - `match_q`, `snz_q` and `stop_q` reset to 1. A match present at reset, or a button held through reset, produces no event.
- **Latency:** `trig` or a button edge sampled at edge N gives the state and output change visible after edge N; `som` is high from the cycle after the trigger.
- **RING length:** `RING_SEC` ticks; the last tick causes the exit. SNOOZE length is likewise `SNOOZE_SEC` ticks.
- **Output source:** all outputs are decoded from registers only. There is no combinational path from inputs to outputs.
- **Reset mid-operation:** asynchronous reset returns to IDLE immediately; a pending snooze is discarded.
- **`tick` coinciding with a button edge:** the button action wins, and the counter is reset rather than incremented.

## Test plan
Bench parameters: `RING_SEC=4`, `SNOOZE_SEC=6`, `MAX_SNOOZE=2`.
1. Alarm 07:30, time steps 07:29:59 → 07:30:00 with `alarm_en=1`: `ringing=1` one cycle later, `som` pattern 1,0,1,0 over 4 ticks, then auto-snooze with `snooze_left=1`, `snoozing=1`.
2. Continue without presses: after 6 ticks RING again; timeout leads to SNOOZE (`snooze_left=0`); after 6 ticks RING; after 4 ticks IDLE with `missed=1`, `som=0`.
3. In RING, pulse `btn_snooze` twice, then a third time: first two presses move to SNOOZE and decrement `snooze_left` to 0; the third press in RING is ignored and ringing continues.
4. In SNOOZE, raise `btn_stop`: IDLE next cycle and `missed` cleared. With time held at 07:30:00 for multiple cycles, no retrigger.
5. `alarm_en=0` at the match second: no ring. Drop `alarm_en` during RING: IDLE next cycle.
6. Assert `rst` during RING with `btn_stop` held: all outputs return to reset values; after release, the held button causes no action until it is released and pressed again.

Source files
------------

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm ring/snooze/auto-stop sequencer for the digital clock
module alarm_sequencer #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [6:0] cur_h,
    input  logic [6:0] cur_m,
    input  logic [6:0] cur_s,
    input  logic [6:0] alm_h,
    input  logic [6:0] alm_m,
    input  logic       alarm_en,
    input  logic       btn_snooze,
    input  logic       btn_stop,
    output logic       som,
    output logic       ringing,
    output logic       snoozing,
    output logic [2:0] snooze_left,
    output logic       missed
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] sec_cnt_q, sec_cnt_d;
    logic [2:0] snz_cnt_q, snz_cnt_d;
    logic       phase_q, phase_d;
    logic       missed_q, missed_d;
    logic       match_q, snz_q, stop_q;

    logic match, trig, snz_rise, stop_rise, snz_avail;

    assign match     = (cur_h == alm_h) && (cur_m == alm_m) && (cur_s == 7'd0);
    assign trig      = match && !match_q && alarm_en;
    assign snz_rise  = btn_snooze && !snz_q;
    assign stop_rise = btn_stop && !stop_q;
    assign snz_avail = snz_cnt_q < 3'(MAX_SNOOZE);

    // Edge-detect history resets high so a level present at reset is not an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sec_cnt_q <= '0;
            snz_cnt_q <= '0;
            phase_q   <= 1'b0;
            missed_q  <= 1'b0;
            match_q   <= 1'b1;
            snz_q     <= 1'b1;
            stop_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            sec_cnt_q <= sec_cnt_d;
            snz_cnt_q <= snz_cnt_d;
            phase_q   <= phase_d;
            missed_q  <= missed_d;
            match_q   <= match;
            snz_q     <= btn_snooze;
            stop_q    <= btn_stop;
        end
    end

    always_comb begin
        state_d   = state_q;
        sec_cnt_d = sec_cnt_q;
        snz_cnt_d = snz_cnt_q;
        phase_d   = phase_q;
        missed_d  = missed_q;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d   = RING;
                    sec_cnt_d = '0;
                    snz_cnt_d = '0;
                    phase_d   = 1'b1;
                end
            end
            RING: begin
                if (!alarm_en || stop_rise) begin
                    state_d = IDLE;
                end else if (snz_rise && snz_avail) begin
                    state_d   = SNOOZE;
                    snz_cnt_d = snz_cnt_q + 3'd1;
                    sec_cnt_d = '0;
                end else if (tick) begin
                    if (sec_cnt_q == 10'(RING_SEC - 1)) begin
                        if (snz_avail) begin
                            state_d   = SNOOZE;
                            snz_cnt_d = snz_cnt_q + 3'd1;
                            sec_cnt_d = '0;
                        end else begin
                            state_d  = IDLE;
                            missed_d = 1'b1;
                        end
                    end else begin
                        sec_cnt_d = sec_cnt_q + 10'd1;
                        phase_d   = !phase_q;
                    end
                end
            end
            SNOOZE: begin
                if (!alarm_en || stop_rise) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (sec_cnt_q == 10'(SNOOZE_SEC - 1)) begin
                        state_d   = RING;
                        sec_cnt_d = '0;
                        phase_d   = 1'b1;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 10'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop_rise || !alarm_en) begin
            missed_d = 1'b0;
        end
    end

    assign ringing     = (state_q == RING);
    assign snoozing    = (state_q == SNOOZE);
    assign som         = ringing && phase_q;
    assign snooze_left = 3'(MAX_SNOOZE) - snz_cnt_q;
    assign missed      = missed_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - self-checking bench for alarm_sequencer with a countdown reference model
module tb_alarm_sequencer;

    localparam int RS = 4;
    localparam int SS = 6;
    localparam int MS = 2;

    logic       clk = 1'b0;
    logic       rst, tick, alarm_en, btn_snooze, btn_stop;
    logic [6:0] cur_h, cur_m, cur_s, alm_h, alm_m;
    logic       som, ringing, snoozing, missed;
    logic [2:0] snooze_left;
    logic [6:0] obs;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: remaining-ticks countdown and elapsed-tick parity.
    bit m_ring, m_snz, m_missed, m_pm, m_ps, m_pt;
    int m_left, m_used, m_elapsed;

    always #5 clk = ~clk;

    alarm_sequencer #(.RING_SEC(RS), .SNOOZE_SEC(SS), .MAX_SNOOZE(MS)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
        .alm_h(alm_h), .alm_m(alm_m), .alarm_en(alarm_en),
        .btn_snooze(btn_snooze), .btn_stop(btn_stop),
        .som(som), .ringing(ringing), .snoozing(snoozing),
        .snooze_left(snooze_left), .missed(missed)
    );

    assign obs = {som, ringing, snoozing, snooze_left, missed};

    function automatic logic [6:0] model_vec();
        logic s;
        s = m_ring && (m_elapsed % 2 == 0);
        return {s, m_ring, m_snz, 3'(MS - m_used), m_missed};
    endfunction

    task automatic model_reset();
        m_ring = 0; m_snz = 0; m_missed = 0;
        m_pm = 1; m_ps = 1; m_pt = 1;
        m_left = 0; m_used = 0; m_elapsed = 0;
    endtask

    task automatic model_edge();
        bit match, trig, sr, st;
        match = (cur_h == alm_h) && (cur_m == alm_m) && (cur_s == 0);
        trig  = match && !m_pm && alarm_en;
        sr    = btn_snooze && !m_ps;
        st    = btn_stop && !m_pt;
        if (!m_ring && !m_snz) begin
            if (trig) begin
                m_ring = 1; m_left = RS; m_used = 0; m_elapsed = 0;
            end
        end else if (!alarm_en || st) begin
            m_ring = 0; m_snz = 0;
        end else if (m_ring) begin
            if (sr && m_used < MS) begin
                m_ring = 0; m_snz = 1; m_used++; m_left = SS;
            end else if (tick) begin
                m_left--; m_elapsed++;
                if (m_left == 0) begin
                    m_ring = 0;
                    if (m_used < MS) begin
                        m_snz = 1; m_used++; m_left = SS;
                    end else begin
                        m_missed = 1;
                    end
                end
            end
        end else if (tick) begin
            m_left--;
            if (m_left == 0) begin
                m_snz = 0; m_ring = 1; m_left = RS; m_elapsed = 0;
            end
        end
        if (st || !alarm_en) m_missed = 0;
        m_pm = match; m_ps = btn_snooze; m_pt = btn_stop;
    endtask

    task automatic step(input bit t);
        tick = t;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        tick = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_h = 7'(h); cur_m = 7'(m); cur_s = 7'(s);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(1);
            step(0);
        end
    endtask

    task automatic trigger();
        set_time(7, 29, 59);
        step(0);
        set_time(7, 30, 0);
        step(0);
    endtask

    task automatic test_reset();
        rst = 1; tick = 0; btn_snooze = 0; btn_stop = 0;
        alarm_en = 1; alm_h = 7'd7; alm_m = 7'd30;
        set_time(7, 30, 0);
        model_reset();
        #2;
        n_checks++;
        if (obs !== 7'b000_010_0) $display("FAIL reset_outputs got %b want %b", obs, 7'b000_010_0);
        else n_pass++;
        step(0); step(0);
        rst = 0;
        step(0); step(0);
        n_checks++;
        if (obs !== 7'b000_010_0) $display("FAIL match_at_reset got %b want %b", obs, 7'b000_010_0);
        else n_pass++;
    endtask

    task automatic test_ring_autosnooze();
        trigger();
        n_checks++;
        if (obs !== 7'b110_010_0) $display("FAIL ring_start got %b want %b", obs, 7'b110_010_0);
        else n_pass++;
        for (int i = 0; i < RS; i++) begin
            n_checks++;
            if (som !== ((i % 2) == 0)) $display("FAIL som_pattern_%0d got %b want %b", i, som, (i % 2) == 0);
            else n_pass++;
            step(1);
            step(0);
        end
        n_checks++;
        if (obs !== 7'b001_001_0) $display("FAIL auto_snooze got %b want %b", obs, 7'b001_001_0);
        else n_pass++;
    endtask

    task automatic test_snooze_cycle();
        ticks(SS - 1);
        n_checks++;
        if (obs !== 7'b001_001_0) $display("FAIL snooze_before_end got %b want %b", obs, 7'b001_001_0);
        else n_pass++;
        ticks(1);
        n_checks++;
        if (obs !== 7'b110_001_0) $display("FAIL reringing got %b want %b", obs, 7'b110_001_0);
        else n_pass++;
        ticks(RS);
        n_checks++;
        if (obs !== 7'b001_000_0) $display("FAIL second_auto_snooze got %b want %b", obs, 7'b001_000_0);
        else n_pass++;
        ticks(SS);
        ticks(RS - 1);
        n_checks++;
        if (obs !== 7'b010_000_0) $display("FAIL last_ring_tick got %b want %b", obs, 7'b010_000_0);
        else n_pass++;
        ticks(1);
        n_checks++;
        if (obs !== 7'b000_000_1) $display("FAIL missed_timeout got %b want %b", obs, 7'b000_000_1);
        else n_pass++;
        repeat (3) step(0);
        n_checks++;
        if (obs !== 7'b000_000_1) $display("FAIL no_retrigger_idle got %b want %b", obs, 7'b000_000_1);
        else n_pass++;
    endtask

    task automatic test_snooze_button();
        trigger();
        btn_snooze = 1;
        step(1);
        btn_snooze = 0;
        n_checks++;
        if (obs !== 7'b001_001_1) $display("FAIL press_with_tick got %b want %b", obs, 7'b001_001_1);
        else n_pass++;
        step(0);
        ticks(SS - 1);
        n_checks++;
        if (obs !== 7'b001_001_1) $display("FAIL counter_cleared got %b want %b", obs, 7'b001_001_1);
        else n_pass++;
        ticks(1);
        btn_snooze = 1; step(0); btn_snooze = 0; step(0);
        n_checks++;
        if (obs !== 7'b001_000_1) $display("FAIL second_press got %b want %b", obs, 7'b001_000_1);
        else n_pass++;
        ticks(SS);
        btn_snooze = 1; step(0);
        n_checks++;
        if (obs !== 7'b110_000_1) $display("FAIL third_press_ignored got %b want %b", obs, 7'b110_000_1);
        else n_pass++;
        btn_snooze = 0; step(0);
        ticks(RS);
        n_checks++;
        if (obs !== 7'b000_000_1) $display("FAIL timeout_after_presses got %b want %b", obs, 7'b000_000_1);
        else n_pass++;
    endtask

    task automatic test_stop();
        trigger();
        btn_snooze = 1; step(0); btn_snooze = 0; step(0);
        btn_stop = 1;
        step(0);
        n_checks++;
        if (obs !== 7'b000_001_0) $display("FAIL stop_in_snooze got %b want %b", obs, 7'b000_001_0);
        else n_pass++;
        repeat (4) step(1);
        n_checks++;
        if (obs !== 7'b000_001_0) $display("FAIL hold_match_no_retrigger got %b want %b", obs, 7'b000_001_0);
        else n_pass++;
        btn_stop = 0;
        step(0);
    endtask

    task automatic test_enable();
        set_time(7, 29, 59);
        step(0);
        alarm_en = 0;
        set_time(7, 30, 0);
        step(0);
        n_checks++;
        if (obs !== 7'b000_001_0) $display("FAIL disabled_no_ring got %b want %b", obs, 7'b000_001_0);
        else n_pass++;
        alarm_en = 1;
        repeat (3) step(0);
        n_checks++;
        if (obs !== 7'b000_001_0) $display("FAIL enable_late_no_ring got %b want %b", obs, 7'b000_001_0);
        else n_pass++;
        trigger();
        alarm_en = 0;
        step(0);
        n_checks++;
        if (obs !== 7'b000_010_0) $display("FAIL drop_en_in_ring got %b want %b", obs, 7'b000_010_0);
        else n_pass++;
        alarm_en = 1;
    endtask

    task automatic test_reset_mid();
        trigger();
        ticks(1);
        btn_snooze = 1; step(0); btn_snooze = 0; step(0);
        ticks(SS);
        btn_stop = 1;
        #2;
        rst = 1;
        model_reset();
        #1;
        n_checks++;
        if (obs !== 7'b000_010_0) $display("FAIL async_reset got %b want %b", obs, 7'b000_010_0);
        else n_pass++;
        step(0); step(0);
        rst = 0;
        step(0);
        trigger();
        n_checks++;
        if (obs !== 7'b110_010_0) $display("FAIL held_stop_no_action got %b want %b", obs, 7'b110_010_0);
        else n_pass++;
        btn_stop = 0; step(0);
        btn_stop = 1; step(0);
        n_checks++;
        if (obs !== 7'b000_010_0) $display("FAIL repressed_stop got %b want %b", obs, 7'b000_010_0);
        else n_pass++;
        btn_stop = 0; step(0);
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) set_time(7, 30, 0);
            else if (r < 7) set_time(7, 29, 59);
            else set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            if ($urandom_range(0, 59) == 0) alarm_en = ~alarm_en;
            if ($urandom_range(0, 9) == 0) btn_snooze = ~btn_snooze;
            if ($urandom_range(0, 29) == 0) btn_stop = ~btn_stop;
            rst = ($urandom_range(0, 799) == 0);
            step($urandom_range(0, 2) == 0);
            rst = 0;
            n_checks++;
            if (obs !== model_vec()) $display("FAIL random_cycle_%0d got %b want %b", i, obs, model_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ring_autosnooze();
        test_snooze_cycle();
        test_snooze_button();
        test_stop();
        test_enable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
